lfsr: RTL and testbench

- Free-running Fibonacci linear-feedback shift register; produces a pseudo-random WIDTH-bit word every clock.
- Default configuration is 32-bit maximal-length (period 2^32-1).
- Used as a pseudo-random source / pattern generator.
- No enable or load interface: runs continuously after reset.

---
 rtl/lfsr.sv | 56 +++++
 tb/tb_lfsr.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR: left shift, XOR-of-taps feedback enters at the LSB.
// Optional macro LFSR_LOCKUP_GUARD_EN forces the all-zero state back to 1.
module lfsr #(
    parameter int unsigned WIDTH = 32,
    parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
    parameter logic [63:0] TAPS  = 64'h0000_0000_8020_0003
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] seed_w = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] taps_w = TAPS[WIDTH-1:0];

    // Configuration errors are caught at elaboration.
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("lfsr: WIDTH=%0d outside legal range 2..64", WIDTH);
    end
    if (taps_w[WIDTH-1] == 1'b0) begin : g_bad_taps
        $error("lfsr: TAPS must have bit WIDTH-1 set");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_state;
    logic             fb;

`ifdef LFSR_LOCKUP_GUARD_EN
    logic zero_det;
`endif

    always_comb begin
        fb         = ^(state & taps_w);
        shifted    = {state[WIDTH-2:0], fb};
        next_state = shifted;
`ifdef LFSR_LOCKUP_GUARD_EN
        // All-zero is absorbing under XOR feedback; kick it back to 1.
        zero_det = (state == '0);
        if (zero_det) begin
            next_state = WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed_w;
        end else begin
            state <= next_state;
        end
    end

    assign out = state;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: default 32-bit sequence, resets, model compare,
// 8-bit period check and all-zero seed behaviour with/without the lockup guard.
module tb_lfsr;

    logic        clk = 1'b0;
    logic        rst32;
    logic        rst8;
    logic        rst8z;
    logic [31:0] out32;
    logic [7:0]  out8;
    logic [7:0]  out8z;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    lfsr u32 (
        .clk (clk),
        .rst (rst32),
        .out (out32)
    );

    lfsr #(.WIDTH(8), .SEED(64'h01), .TAPS(64'hB8)) u8 (
        .clk (clk),
        .rst (rst8),
        .out (out8)
    );

    lfsr #(.WIDTH(8), .SEED(64'h00), .TAPS(64'hE1)) u8z (
        .clk (clk),
        .rst (rst8z),
        .out (out8z)
    );

    function automatic logic [31:0] model32(input logic [31:0] s);
        logic [31:0] taps;
        taps = 32'h8020_0003;
        return {s[30:0], ^(s & taps)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [6];
        exp_seq = '{32'h01, 32'h03, 32'h06, 32'h0D, 32'h1B, 32'h36};
        rst32 = 1'b1;
        tick();
        rst32 = 1'b0;
        checks++;
        if (out32 !== exp_seq[0]) begin
            errors++;
            $display("FAIL reset_seed: got %h expected %h", out32, exp_seq[0]);
        end
        for (int i = 1; i < 6; i++) begin
            tick();
            checks++;
            if (out32 !== exp_seq[i]) begin
                errors++;
                $display("FAIL default_seq[%0d]: got %h expected %h", i, out32, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_held();
        rst32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out32 !== 32'h1) begin
                errors++;
                $display("FAIL reset_held[%0d]: got %h expected 00000001", i, out32);
            end
        end
        rst32 = 1'b0;
        tick();
        checks++;
        if (out32 !== 32'h3) begin
            errors++;
            $display("FAIL reset_release: got %h expected 00000003", out32);
        end
    endtask

    task automatic test_mid_run_reset();
        logic [31:0] m;
        m = 32'h3;
        for (int i = 0; i < 100; i++) begin
            tick();
            m = model32(m);
        end
        checks++;
        if (out32 !== m) begin
            errors++;
            $display("FAIL pre_reset_run: got %h expected %h", out32, m);
        end
        rst32 = 1'b1;
        tick();
        rst32 = 1'b0;
        checks++;
        if (out32 !== 32'h1) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 00000001", out32);
        end
        tick();
        checks++;
        if (out32 !== 32'h3) begin
            errors++;
            $display("FAIL mid_reset_restart: got %h expected 00000003", out32);
        end
    endtask

    task automatic test_model_compare();
        logic [31:0] m;
        int mism;
        int zeros;
        mism  = 0;
        zeros = 0;
        rst32 = 1'b1;
        tick();
        rst32 = 1'b0;
        m = 32'h1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            m = model32(m);
            if (out32 !== m) begin
                if (mism < 5) $display("FAIL model_cycle[%0d]: got %h expected %h", i, out32, m);
                mism++;
            end
            if (out32 === 32'h0) zeros++;
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL model_compare: mismatching cycles %0d expected 0", mism);
        end
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL never_zero: zero cycles %0d expected 0", zeros);
        end
    endtask

    task automatic test_period8();
        bit seen [256];
        int steps;
        int dups;
        int distinct;
        bit found;
        foreach (seen[k]) seen[k] = 1'b0;
        steps = 0;
        dups  = 0;
        found = 1'b0;
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        checks++;
        if (out8 !== 8'h01) begin
            errors++;
            $display("FAIL period8_seed: got %h expected 01", out8);
        end
        seen[1] = 1'b1;
        for (int i = 1; i <= 300 && !found; i++) begin
            tick();
            if (out8 === 8'h01) begin
                found = 1'b1;
                steps = i;
            end else if ($isunknown(out8) || out8 == 8'h00 || seen[int'(out8)]) begin
                dups++;
            end else begin
                seen[int'(out8)] = 1'b1;
            end
        end
        checks++;
        if (!found || steps != 255) begin
            errors++;
            $display("FAIL period8_length: got %0d (found=%0d) expected 255", steps, found);
        end
        checks++;
        if (dups != 0) begin
            errors++;
            $display("FAIL period8_repeats: got %0d expected 0", dups);
        end
        distinct = 0;
        for (int k = 1; k < 256; k++) if (seen[k]) distinct++;
        checks++;
        if (distinct != 255) begin
            errors++;
            $display("FAIL period8_coverage: got %0d expected 255", distinct);
        end
    endtask

    task automatic test_lockup();
        rst8z = 1'b1;
        tick();
        rst8z = 1'b0;
        checks++;
        if (out8z !== 8'h00) begin
            errors++;
            $display("FAIL lockup_seed: got %h expected 00", out8z);
        end
`ifdef LFSR_LOCKUP_GUARD_EN
        tick();
        checks++;
        if (out8z !== 8'h01) begin
            errors++;
            $display("FAIL lockup_recover: got %h expected 01", out8z);
        end
        tick();
        checks++;
        if (out8z !== 8'h03) begin
            errors++;
            $display("FAIL lockup_next: got %h expected 03", out8z);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out8z !== 8'h00) begin
                errors++;
                $display("FAIL lockup_hold[%0d]: got %h expected 00", i, out8z);
            end
        end
`endif
    endtask

    initial begin
        rst32 = 1'b0;
        rst8  = 1'b0;
        rst8z = 1'b0;
        #1;
        test_reset();
        test_reset_held();
        test_mid_run_reset();
        test_model_compare();
        test_period8();
        test_lockup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
